// File: rtl/iter_div.sv
// Iterative 32-bit restoring divider with AXI-Stream style operand inputs.
// One quotient bit is produced per cycle; the result is a one-cycle pulse of
// {quotient, remainder}. SIGNED selects two's-complement or unsigned operation.
module iter_div #(
   parameter bit SIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_axis_dividend_tvalid,
   output logic        s_axis_dividend_tready,
   input  logic [31:0] s_axis_dividend_tdata,
   input  logic        s_axis_divisor_tvalid,
   output logic        s_axis_divisor_tready,
   input  logic [31:0] s_axis_divisor_tdata,
   output logic        m_axis_dout_tvalid,
   output logic [63:0] m_axis_dout_tdata
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic [31:0] rem_q;       // partial remainder
   logic [31:0] quo_q;       // dividend bits shift out, quotient bits shift in
   logic [31:0] dvs_q;       // divisor magnitude
   logic        q_neg_q;
   logic        r_neg_q;
   logic [63:0] dout_tdata_q;
   logic        dout_tvalid_q;

   logic        dvd_neg;
   logic        dvs_neg;
   logic [31:0] dvd_mag;
   logic [31:0] dvs_mag;
   logic [32:0] shifted;
   logic [33:0] trial;
   logic        fits;
   logic        unused_trial_bit;
   logic [31:0] rem_step;
   logic [31:0] quo_step;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // Operand magnitudes, one restoring step, and final sign correction.
   always_comb begin
      dvd_neg  = SIGNED & s_axis_dividend_tdata[31];
      dvs_neg  = SIGNED & s_axis_divisor_tdata[31];
      dvd_mag  = dvd_neg ? (32'd0 - s_axis_dividend_tdata) : s_axis_dividend_tdata;
      dvs_mag  = dvs_neg ? (32'd0 - s_axis_divisor_tdata) : s_axis_divisor_tdata;
      shifted  = {rem_q, quo_q[31]};
      trial    = {1'b0, shifted} - {2'b00, dvs_q};
      fits     = ~trial[33];
      // When the subtract fits the difference is below the divisor, so bit 32 is always 0.
      unused_trial_bit = trial[32];
      rem_step = fits ? trial[31:0] : shifted[31:0];
      quo_step = {quo_q[30:0], fits};
      quo_fix  = q_neg_q ? (32'd0 - quo_step) : quo_step;
      rem_fix  = r_neg_q ? (32'd0 - rem_step) : rem_step;
   end

   // Both operand channels share one handshake: ready only while idle.
   always_comb begin
      s_axis_dividend_tready = (state_q == StIdle);
      s_axis_divisor_tready  = (state_q == StIdle);
      m_axis_dout_tvalid     = dout_tvalid_q;
      m_axis_dout_tdata      = dout_tdata_q;
   end

   // Control FSM and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= 6'd0;
         rem_q         <= 32'd0;
         quo_q         <= 32'd0;
         dvs_q         <= 32'd0;
         q_neg_q       <= 1'b0;
         r_neg_q       <= 1'b0;
         dout_tdata_q  <= 64'd0;
         dout_tvalid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (s_axis_dividend_tvalid && s_axis_divisor_tvalid) begin
                  rem_q   <= 32'd0;
                  quo_q   <= dvd_mag;
                  dvs_q   <= dvs_mag;
                  q_neg_q <= dvd_neg ^ dvs_neg;
                  r_neg_q <= dvd_neg;
                  cnt_q   <= 6'd0;
                  state_q <= StBusy;
               end
            end
            StBusy: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  dout_tdata_q  <= {quo_fix, rem_fix};
                  dout_tvalid_q <= 1'b1;
                  state_q       <= StDone;
               end
            end
            StDone: begin
               dout_tvalid_q <= 1'b0;
               state_q       <= StIdle;
            end
            default: begin
               dout_tvalid_q <= 1'b0;
               state_q       <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_div.sv
// Bench for iter_div: a signed and an unsigned instance share all inputs.
module tb_iter_div;

   logic        clk;
   logic        reset;
   logic        dvd_valid;
   logic        dvs_valid;
   logic [31:0] dvd_data;
   logic [31:0] dvs_data;
   logic        dvd_ready_s, dvs_ready_s, vld_s;
   logic        dvd_ready_u, dvs_ready_u, vld_u;
   logic [63:0] dout_s, dout_u;

   int checks = 0;
   int errors = 0;
   int pulses_s = 0;
   int pulses_u = 0;
   logic [63:0] sb_s[$];
   logic [63:0] sb_u[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   iter_div #(.SIGNED(1'b1)) u_dut_s (
      .clk                    (clk),
      .reset                  (reset),
      .s_axis_dividend_tvalid (dvd_valid),
      .s_axis_dividend_tready (dvd_ready_s),
      .s_axis_dividend_tdata  (dvd_data),
      .s_axis_divisor_tvalid  (dvs_valid),
      .s_axis_divisor_tready  (dvs_ready_s),
      .s_axis_divisor_tdata   (dvs_data),
      .m_axis_dout_tvalid     (vld_s),
      .m_axis_dout_tdata      (dout_s)
   );

   iter_div #(.SIGNED(1'b0)) u_dut_u (
      .clk                    (clk),
      .reset                  (reset),
      .s_axis_dividend_tvalid (dvd_valid),
      .s_axis_dividend_tready (dvd_ready_u),
      .s_axis_dividend_tdata  (dvd_data),
      .s_axis_divisor_tvalid  (dvs_valid),
      .s_axis_divisor_tready  (dvs_ready_u),
      .s_axis_divisor_tdata   (dvs_data),
      .m_axis_dout_tvalid     (vld_u),
      .m_axis_dout_tdata      (dout_u)
   );

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: language divide/modulo plus the defined zero and overflow cases.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input bit sgn);
      logic [31:0] q, r;
      int sa, sb;
      if (b == 32'd0) begin
         q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
         r = a;
      end else if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return {q, r};
   endfunction

   // Scoreboard: every result pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (vld_s === 1'b1) begin
         pulses_s++;
         if (sb_s.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse_s: got dout %h expected no pulse", dout_s);
         end else begin
            check64("result_s", dout_s, sb_s.pop_front());
         end
      end
      if (vld_u === 1'b1) begin
         pulses_u++;
         if (sb_u.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse_u: got dout %h expected no pulse", dout_u);
         end else begin
            check64("result_u", dout_u, sb_u.pop_front());
         end
      end
   end

   task automatic wait_ready();
      int k = 0;
      while (dvd_ready_s !== 1'b1 && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      check64("ready_wait", {63'd0, dvd_ready_s}, 64'd1);
   endtask

   // One operation with latency, busy-ready and output-hold checks.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_s, input logic [63:0] exp_u);
      int   n;
      logic seen_ready;
      wait_ready();
      dvd_data  = a;
      dvs_data  = b;
      dvd_valid = 1'b1;
      dvs_valid = 1'b1;
      sb_s.push_back(exp_s);
      sb_u.push_back(exp_u);
      @(posedge clk);
      #1;
      dvd_valid  = 1'b0;
      dvs_valid  = 1'b0;
      dvd_data   = $urandom;
      dvs_data   = $urandom;
      n          = 0;
      seen_ready = dvd_ready_s | dvs_ready_s | dvd_ready_u | dvs_ready_u;
      while (vld_s !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         seen_ready |= dvd_ready_s | dvs_ready_s | dvd_ready_u | dvs_ready_u;
      end
      check64("latency", 64'(n), 64'd32);
      check64("ready_low_busy", {63'd0, seen_ready}, 64'd0);
      check64("vld_u_aligned", {63'd0, vld_u}, 64'd1);
      @(posedge clk);
      #1;
      check64("vld_after_done", {62'd0, vld_s, vld_u}, 64'd0);
      check64("ready_after_done", {60'd0, dvd_ready_s, dvs_ready_s, dvd_ready_u, dvs_ready_u},
              64'hF);
      check64("hold_s", dout_s, exp_s);
      check64("hold_u", dout_u, exp_u);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      bit          sgn;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int          p0_s, p0_u, cyc, last, i, k;
      logic        rdy, ok;
      logic [31:0] bb_a[3];
      logic [31:0] bb_b[3];
      logic [31:0] ra, rb;

      vecs[0] = '{32'd100,        32'd7,          64'h0000000E_00000002, 1'b0};
      vecs[1] = '{32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFD_FFFFFFFF, 1'b1};
      vecs[2] = '{32'd7,          32'hFFFF_FFFE,  64'hFFFFFFFD_00000001, 1'b1};
      vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000, 1'b1};
      vecs[4] = '{32'hFFFF_FFFF,  32'd1,          64'hFFFFFFFF_00000000, 1'b0};
      vecs[5] = '{32'd5,          32'd0,          64'hFFFFFFFF_00000005, 1'b0};
      vecs[6] = '{32'hFFFF_FFFB,  32'd0,          64'h00000001_FFFFFFFB, 1'b1};
      vecs[7] = '{32'd0,          32'd9,          64'h00000000_00000000, 1'b0};
      vecs[8] = '{32'd100,        32'd7,          64'h0000000E_00000002, 1'b1};
      vecs[9] = '{32'h1234_5678,  32'h0000_1000,  64'h00012345_00000678, 1'b0};

      // Reset with both valids high: nothing may be accepted.
      reset     = 1'b1;
      dvd_valid = 1'b1;
      dvs_valid = 1'b1;
      dvd_data  = 32'd100;
      dvs_data  = 32'd7;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check64("rst_ready", {60'd0, dvd_ready_s, dvs_ready_s, dvd_ready_u, dvs_ready_u}, 64'hF);
      check64("rst_vld", {62'd0, vld_s, vld_u}, 64'd0);
      check64("rst_dout_s", dout_s, 64'd0);
      check64("rst_dout_u", dout_u, 64'd0);
      dvd_valid = 1'b0;
      dvs_valid = 1'b0;
      reset     = 1'b0;

      // Table-driven vectors; the non-tabled mode uses the reference model.
      for (int v = 0; v < 10; v++) begin
         run_op(vecs[v].a, vecs[v].b,
                vecs[v].sgn ? vecs[v].exp : ref_div(vecs[v].a, vecs[v].b, 1'b1),
                vecs[v].sgn ? ref_div(vecs[v].a, vecs[v].b, 1'b0) : vecs[v].exp);
      end

      for (int v = 0; v < 4; v++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 28);
         run_op(ra, rb, ref_div(ra, rb, 1'b1), ref_div(ra, rb, 1'b0));
      end

      // Both valids held high: one accept every 34 cycles.
      bb_a[0] = 32'd1000;        bb_b[0] = 32'd33;
      bb_a[1] = 32'hFFFF_FC18;   bb_b[1] = 32'd33;
      bb_a[2] = 32'h7FFF_FFFF;   bb_b[2] = 32'hFFFF_FFFD;
      wait_ready();
      dvd_data  = bb_a[0];
      dvs_data  = bb_b[0];
      dvd_valid = 1'b1;
      dvs_valid = 1'b1;
      i    = 0;
      cyc  = 0;
      last = -1;
      while (i < 3 && cyc < 200) begin
         @(negedge clk);
         rdy = dvd_ready_s;
         if (rdy) begin
            sb_s.push_back(ref_div(dvd_data, dvs_data, 1'b1));
            sb_u.push_back(ref_div(dvd_data, dvs_data, 1'b0));
         end
         @(posedge clk);
         cyc++;
         #1;
         if (rdy) begin
            if (last >= 0) check64("b2b_spacing", 64'(cyc - last), 64'd34);
            last = cyc;
            i++;
            if (i < 3) begin
               dvd_data = bb_a[i];
               dvs_data = bb_b[i];
            end
         end
      end
      dvd_valid = 1'b0;
      dvs_valid = 1'b0;
      check64("b2b_accepts", 64'(i), 64'd3);
      k = 0;
      while ((sb_s.size() != 0 || sb_u.size() != 0) && k < 60) begin
         @(posedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      check64("b2b_drained", 64'(sb_s.size() + sb_u.size()), 64'd0);

      // Divisor valid alone must never start an operation.
      p0_s      = pulses_s;
      p0_u      = pulses_u;
      dvs_data  = 32'd3;
      dvd_data  = 32'd9;
      dvs_valid = 1'b1;
      ok        = 1'b1;
      repeat (40) begin
         @(posedge clk);
         #1;
         ok &= dvd_ready_s & dvs_ready_s & dvd_ready_u & dvs_ready_u;
      end
      dvs_valid = 1'b0;
      check64("divisor_only_ready", {63'd0, ok}, 64'd1);
      check64("divisor_only_pulses", 64'(pulses_s + pulses_u - p0_s - p0_u), 64'd0);

      // Reset during iteration 10 aborts without a result pulse.
      wait_ready();
      dvd_data  = 32'd100;
      dvs_data  = 32'd7;
      dvd_valid = 1'b1;
      dvs_valid = 1'b1;
      @(posedge clk);
      #1;
      dvd_valid = 1'b0;
      dvs_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check64("abort_ready", {60'd0, dvd_ready_s, dvs_ready_s, dvd_ready_u, dvs_ready_u}, 64'hF);
      check64("abort_vld", {62'd0, vld_s, vld_u}, 64'd0);
      check64("abort_dout", dout_s | dout_u, 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      p0_s  = pulses_s;
      p0_u  = pulses_u;
      repeat (40) @(posedge clk);
      #1;
      check64("abort_no_pulse", 64'(pulses_s + pulses_u - p0_s - p0_u), 64'd0);
      run_op(32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002);

      repeat (3) @(posedge clk);
      #1;
      check64("final_drained", 64'(sb_s.size() + sb_u.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
